// File: rtl/pll_mode_sequencer_if.sv
// Mode-request handshake between a video-mode controller and the PLL sequencer.
interface pll_mode_sequencer_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;

  modport master (output cfg_valid, output cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_mode, output cfg_ready);
endinterface

// File: rtl/pll_mode_sequencer.sv
// Video PLL mode sequencer: drives dynamic divider codes, qualifies LOCK, retries on timeout.
// Optional PLL reset output enabled by `define PLL_MODE_SEQUENCER_PLL_RESET_EN.
module pll_mode_sequencer #(
  parameter int unsigned DEFAULT_MODE        = 0,
  parameter int unsigned SETTLE_CYCLES       = 64,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 2700000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  pll_mode_sequencer_if.slave  cfg,
  input  logic                 pll_lock,
  output logic [5:0]           idsel,
  output logic [5:0]           fbdsel,
  output logic [5:0]           odsel,
  output logic                 video_rst,
  output logic [1:0]           cur_mode,
  output logic                 done,
  output logic                 fault,
  output logic                 lock_lost
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
  ,
  output logic                 pll_reset
`endif
);

  localparam int unsigned CODE_W  = 6;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned CODES_W = 3 * CODE_W;
  localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_APPLY,
    S_SETTLE,
    S_WAIT_LOCK,
    S_RUN,
    S_FAULT
  } state_t;

  // {idsel, fbdsel, odsel} for a mode; 6-bit wrap makes a divisor of 64 encode to 0
  function automatic logic [CODES_W-1:0] codes_for(input logic [MODE_W-1:0] m);
    logic [6:0] idiv, fbdiv, odiv;
    case (m)
      2'd0:    begin idiv = 7'd15; fbdiv = 7'd14; odiv = 7'd16; end
      2'd1:    begin idiv = 7'd1;  fbdiv = 7'd1;  odiv = 7'd16; end
      2'd2:    begin idiv = 7'd4;  fbdiv = 7'd11; odiv = 7'd8;  end
      default: begin idiv = 7'd2;  fbdiv = 7'd11; odiv = 7'd4;  end
    endcase
    return {CODE_W'(7'd64 - idiv), CODE_W'(7'd64 - fbdiv), CODE_W'(7'd64 - (odiv >> 1))};
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     stab_q, stab_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [CODES_W-1:0]   codes_q, codes_d;
  logic                 video_rst_q, video_rst_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 fault_q, fault_d;
  logic                 lost_q, lost_d;
  logic                 lock_meta_q, lock_sync_q;
  logic                 xfer;
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
  logic                 prst_q, prst_d;
  logic [3:0]           prst_cnt_q, prst_cnt_d;
`endif

  assign xfer = cfg.cfg_valid & ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stab_d      = stab_q;
    retry_d     = retry_q;
    mode_d      = mode_q;
    codes_d     = codes_q;
    video_rst_d = 1'b1;
    done_d      = 1'b0;
    fault_d     = fault_q;
    lost_d      = lost_q;
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
    prst_d      = 1'b0;
    prst_cnt_d  = prst_cnt_q;
`endif

    case (state_q)
      S_APPLY: begin
        cnt_d   = '0;
        stab_d  = '0;
        state_d = S_SETTLE;
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
        prst_d     = 1'b1;
        prst_cnt_d = '0;
`endif
      end
      S_SETTLE: begin
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
        // settle counting is held off while the PLL is still in reset
        if (prst_q) begin
          prst_cnt_d = prst_cnt_q + 4'd1;
          prst_d     = (prst_cnt_q != 4'd15);
        end else
`endif
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          stab_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        cnt_d  = cnt_q + CNT_W'(1);
        stab_d = lock_sync_q ? stab_q + CNT_W'(1) : '0;
        // qualification is checked first so it wins over a coincident timeout
        if (lock_sync_q && (stab_q == CNT_W'(LOCK_STABLE_CYCLES - 1))) begin
          state_d = S_RUN;
          done_d  = 1'b1;
          retry_d = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (retry_q < RETRY_W'(MAX_RETRIES)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_APPLY;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!lock_sync_q) begin
          lost_d  = 1'b1;
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          stab_d  = '0;
          retry_d = '0;
        end else begin
          video_rst_d = 1'b0;
        end
      end
      S_FAULT: ;
      default: state_d = S_APPLY;
    endcase

    // an accepted request overrides anything decided in RUN/FAULT above
    if (xfer) begin
      state_d     = S_APPLY;
      mode_d      = cfg.cfg_mode;
      fault_d     = 1'b0;
      lost_d      = 1'b0;
      retry_d     = '0;
      video_rst_d = 1'b1;
    end

    if (state_d == S_APPLY) begin
      codes_d = codes_for(mode_d);
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
      prst_d     = 1'b1;
      prst_cnt_d = '0;
`endif
    end

    ready_d = (state_d == S_RUN) || (state_d == S_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_APPLY;
      cnt_q       <= '0;
      stab_q      <= '0;
      retry_q     <= '0;
      mode_q      <= MODE_W'(DEFAULT_MODE);
      codes_q     <= codes_for(MODE_W'(DEFAULT_MODE));
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      lost_q      <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
      prst_q      <= 1'b1;
      prst_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      retry_q     <= retry_d;
      mode_q      <= mode_d;
      codes_q     <= codes_d;
      video_rst_q <= video_rst_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      lost_q      <= lost_d;
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
      prst_q      <= prst_d;
      prst_cnt_q  <= prst_cnt_d;
`endif
    end
  end

  assign idsel         = codes_q[17:12];
  assign fbdsel        = codes_q[11:6];
  assign odsel         = codes_q[5:0];
  assign video_rst     = video_rst_q;
  assign cur_mode      = mode_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign lock_lost     = lost_q;
  assign cfg.cfg_ready = ready_q;
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
  assign pll_reset     = prst_q;
`endif

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed bench for pll_mode_sequencer: qualification, mode change, lock loss, glitches, retry/fault, reset.
module tb_pll_mode_sequencer;

`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
  localparam int PR = 16;
`else
  localparam int PR = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic lock_a = 1'b0;
  logic lock_b = 1'b0;
  logic [5:0] idsel_a, fbdsel_a, odsel_a, idsel_b, fbdsel_b, odsel_b;
  logic [1:0] cur_mode_a, cur_mode_b;
  logic video_rst_a, done_a, fault_a, lost_a;
  logic video_rst_b, done_b, fault_b, lost_b;
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
  logic pll_reset_a, pll_reset_b;
`endif

  pll_mode_sequencer_if cfg_a ();
  pll_mode_sequencer_if cfg_b ();

  pll_mode_sequencer #(.LOCK_TIMEOUT_CYCLES(4000)) u_dut (
    .clk(clk), .reset(reset), .cfg(cfg_a), .pll_lock(lock_a),
    .idsel(idsel_a), .fbdsel(fbdsel_a), .odsel(odsel_a), .video_rst(video_rst_a),
    .cur_mode(cur_mode_a), .done(done_a), .fault(fault_a), .lock_lost(lost_a)
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
    , .pll_reset(pll_reset_a)
`endif
  );

  pll_mode_sequencer #(.LOCK_TIMEOUT_CYCLES(200)) u_flt (
    .clk(clk), .reset(reset), .cfg(cfg_b), .pll_lock(lock_b),
    .idsel(idsel_b), .fbdsel(fbdsel_b), .odsel(odsel_b), .video_rst(video_rst_b),
    .cur_mode(cur_mode_b), .done(done_b), .fault(fault_b), .lock_lost(lost_b)
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
    , .pll_reset(pll_reset_b)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_finished = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done_a && n < bound);
  endtask

  task automatic request(input logic [1:0] m);
    cfg_a.cfg_valid = 1'b1;
    cfg_a.cfg_mode  = m;
    step();
    cfg_a.cfg_valid = 1'b0;
  endtask

  // Fault-path instance: lock never arrives, timeout 200
  initial begin
    int n;
    int nd;
    cfg_b.cfg_valid = 1'b0;
    cfg_b.cfg_mode  = 2'd0;
    @(negedge reset);
    n = 0;
    while (!done_b && n < 3000) begin
      step();
      n++;
    end
    check("flt_done_cycle", n, 4 * (265 + PR));
    check("flt_fault", fault_b, 1);
    check("flt_ready", cfg_b.cfg_ready, 1);
    check("flt_video_rst", video_rst_b, 1);
    check("flt_codes", {idsel_b, fbdsel_b, odsel_b}, {6'd49, 6'd50, 6'd56});
    nd = 0;
    repeat (20) begin
      step();
      if (done_b) nd++;
    end
    check("flt_single_done", nd, 0);
    check("flt_fault_sticky", fault_b, 1);
    cfg_b.cfg_valid = 1'b1;
    cfg_b.cfg_mode  = 2'd3;
    step();
    cfg_b.cfg_valid = 1'b0;
    check("flt_clear_fault", fault_b, 0);
    check("flt_ready_drop", cfg_b.cfg_ready, 0);
    check("flt_new_mode", cur_mode_b, 3);
    mon_finished = 1'b1;
  end

  initial begin
    int n;
    int nd;
    bit vr_low;
    cfg_a.cfg_valid = 1'b0;
    cfg_a.cfg_mode  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_codes", {idsel_a, fbdsel_a, odsel_a}, {6'd49, 6'd50, 6'd56});
    check("rst_video_rst", video_rst_a, 1);
    check("rst_ready", cfg_a.cfg_ready, 0);
    check("rst_done", done_a, 0);
    check("rst_fault", fault_a, 0);
    check("rst_lock_lost", lost_a, 0);
    check("rst_cur_mode", cur_mode_a, 0);
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
    check("rst_pll_reset", pll_reset_a, 1);
`endif

    // T1: lock rises before edge 100 -> synced at 101, 1024 stable edges
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (n < 2000 && !done_a) begin
      if (n == 99) lock_a = 1'b1;
      step();
      n++;
    end
    check("t1_done_cycle", n, 1125);
    check("t1_video_rst_hold", video_rst_a, 1);
    check("t1_ready", cfg_a.cfg_ready, 1);
    step();
    check("t1_done_pulse", done_a, 0);
    check("t1_video_rst_fall", video_rst_a, 0);

    // T2: mode 2 request while running
    request(2'd2);
    check("t2_ready_drop", cfg_a.cfg_ready, 0);
    check("t2_codes", {idsel_a, fbdsel_a, odsel_a}, {6'd60, 6'd53, 6'd60});
    check("t2_cur_mode", cur_mode_a, 2);
    n = 0;
    vr_low = 1'b0;
    while (n < 2000 && !done_a) begin
      step();
      n++;
      if (!video_rst_a) vr_low = 1'b1;
    end
    check("t2_latency_window", (n >= 1089 + PR) && (n <= 1091 + PR), 1);
    check("t2_video_rst_held", vr_low, 0);
    step();
    check("t2_video_rst_fall", video_rst_a, 0);

    // T3: lock drops for 5 cycles in RUN
    lock_a = 1'b0;
    repeat (3) step();
    check("t3_lock_lost", lost_a, 1);
    check("t3_video_rst", video_rst_a, 1);
    check("t3_ready", cfg_a.cfg_ready, 0);
    repeat (2) step();
    lock_a = 1'b1;
    wait_done(2000, n);
    check("t3_requal_cycle", n, 1026);
    check("t3_lock_lost_sticky", lost_a, 1);
    check("t3_fault", fault_a, 0);
    step();

    // T4: same-mode transfer coinciding with a synced lock drop
    lock_a = 1'b0;
    repeat (2) step();
    request(2'd2);
    check("t4_lock_lost_clear", lost_a, 0);
    check("t4_ready_drop", cfg_a.cfg_ready, 0);
    check("t4_video_rst", video_rst_a, 1);
    lock_a = 1'b1;
    wait_done(2000, n);
    check("t4_latency_window", (n >= 1089 + PR) && (n <= 1091 + PR), 1);
    check("t4_lock_lost_after", lost_a, 0);
    step();

    // T5: single-cycle glitches every 500 cycles block qualification
    request(2'd1);
    check("t5_codes", {idsel_a, fbdsel_a, odsel_a}, {6'd63, 6'd63, 6'd56});
    nd = 0;
    for (int i = 0; i < 1500; i++) begin
      lock_a = (i % 500 == 499) ? 1'b0 : 1'b1;
      step();
      if (done_a) nd++;
    end
    check("t5_no_qual", nd, 0);
    lock_a = 1'b1;
    wait_done(2000, n);
    check("t5_qual_after_glitch", n, 1026);
    step();

    // T6: mode 3 request, requests held off in WAIT_LOCK, reset mid-sequence
    lock_a = 1'b0;
    request(2'd3);
    check("t6_codes", {idsel_a, fbdsel_a, odsel_a}, {6'd62, 6'd53, 6'd62});
    cfg_a.cfg_valid = 1'b1;
    cfg_a.cfg_mode  = 2'd0;
    repeat (200) step();
    check("t6_held_off_mode", cur_mode_a, 3);
    check("t6_held_off_ready", cfg_a.cfg_ready, 0);
    cfg_a.cfg_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_video_rst", video_rst_a, 1);
    check("t6_rst_cur_mode", cur_mode_a, 0);
    check("t6_rst_fault", fault_a, 0);
    check("t6_rst_codes", {idsel_a, fbdsel_a, odsel_a}, {6'd49, 6'd50, 6'd56});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    lock_a = 1'b1;
`ifdef PLL_MODE_SEQUENCER_PLL_RESET_EN
    #1;
    check("t6_pll_reset_apply", pll_reset_a, 1);
    n = 0;
    step();
    while (pll_reset_a && n < 100) begin
      n++;
      step();
    end
    check("t6_pll_reset_len", n, 16);
`endif
    wait_done(2500, n);
    check("t6_resume_done", done_a, 1);
    check("t6_resume_mode", cur_mode_a, 0);

    check("flt_monitor_finished", mon_finished, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_mode_sequencer.md
Name: pll_mode_sequencer

Overview:
- Control-side counterpart of the dynamically reconfigurable video PLL (27 MHz reference).
- Translates a requested video mode into dynamic IDSEL/FBDSEL/ODSEL codes and drives them to the PLL.
- Supervises PLL LOCK: settle wait, stable-lock qualification, timeout with retry.
- Holds the pixel-domain reset until the new clock is qualified; reports completion and faults through a valid/ready handshake.

Parameters:
- DEFAULT_MODE, 0, mode index applied after reset.
- SETTLE_CYCLES, 64, cycles after new codes are driven before LOCK is sampled.
- LOCK_STABLE_CYCLES, 1024, consecutive LOCK-high cycles required to qualify.
- LOCK_TIMEOUT_CYCLES, 2700000, cycles in WAIT_LOCK before a retry (100 ms at 27 MHz).
- MAX_RETRIES, 3, retries before FAULT.
- CNT_W, 24, width of the shared settle/stable/timeout counter.

Ports:
- clk  in  1  27 MHz free-running control clock, same as the PLL reference.
- reset  in  1  asynchronous, active-high.
- cfg_valid  in  1  mode request valid.
- cfg_ready  out  1  sequencer accepts a request.
- cfg_mode  in  2  0=25.2 MHz, 1=27 MHz, 2=74.25 MHz, 3=148.5 MHz.
- pll_lock  in  1  PLL LOCK (asynchronous; double-flopped internally).
- idsel  out  6  dynamic input-divider code.
- fbdsel  out  6  dynamic feedback-divider code.
- odsel  out  6  dynamic output-divider code.
- video_rst  out  1  pixel-domain reset, active-high.
- cur_mode  out  2  mode currently driven.
- done  out  1  one-cycle pulse when a sequence ends (qualified or FAULT).
- fault  out  1  sticky; set on retry exhaustion.
- lock_lost  out  1  sticky; set when lock drops in RUN.

Behaviour:
- Divider table as (IDIV, FBDIV, ODIV): mode0 (15,14,16); mode1 (1,1,16); mode2 (4,11,8); mode3 (2,11,4). Every VCO frequency lies in 400–600 MHz.
- Code encoding: idsel = 64-IDIV, fbdsel = 64-FBDIV, odsel = 64-ODIV/2. All arithmetic is 6-bit, so a divisor of 64 encodes to 0.
- Codes are registered. They change only on the cycle of entry to APPLY.
- States: APPLY, SETTLE, WAIT_LOCK, RUN, FAULT.
- Reset values: state=APPLY, cur_mode=DEFAULT_MODE, codes for DEFAULT_MODE, video_rst=1, cfg_ready=0, done=0, fault=0, lock_lost=0, retry count=0, counter=0.
- APPLY (1 cycle): asserts video_rst, clears the counter, then goes to SETTLE.
- SETTLE: counts to SETTLE_CYCLES-1, then goes to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - Synchronized lock high: increment the stable count; at LOCK_STABLE_CYCLES go to RUN, pulse done, clear retries.
  - Lock low: the stable count restarts.
  - The timeout counter runs independently. At LOCK_TIMEOUT_CYCLES: if retries < MAX_RETRIES, increment retries and go to APPLY (same mode); otherwise go to FAULT, set fault, pulse done.
- RUN: video_rst=0 on the cycle after entry. If synchronized lock goes low: set lock_lost, video_rst=1, go to WAIT_LOCK, retries reset to 0.
- FAULT: video_rst stays 1. Codes stay at the last mode.
- Handshake:
  - cfg_ready=1 only in RUN and FAULT.
  - A transfer occurs when cfg_valid&cfg_ready. It latches cfg_mode into cur_mode, clears fault and lock_lost, and enters APPLY (cfg_ready drops the next cycle).
  - cfg_valid outside RUN/FAULT is held off, not dropped.
  - A request for the same mode as cur_mode still performs a full sequence.
- Simultaneous events:
  - A transfer in the same cycle as a lock drop in RUN: the transfer wins; lock_lost is not set.
  - Timeout and stable-qualification in the same cycle: qualification wins.
- Reset asserted mid-sequence returns all outputs to reset values immediately (asynchronous). Sequencing resumes with DEFAULT_MODE.
- Latency: cfg transfer to earliest done is 1 + SETTLE_CYCLES + LOCK_STABLE_CYCLES + sync delay (2) cycles.

Optional Feature:
- Macro: PLL_MODE_SEQUENCER_PLL_RESET_EN.
- When defined:
  - Adds output pll_reset (1 bit, reset value 1).
  - Asserted in APPLY and held for 16 cycles into SETTLE on every APPLY entry, including retries. SETTLE counting starts after its release.
  - The integrating wrapper ties pll_reset to the PLL RESET.
- When undefined: the port is absent. Retries only re-drive codes and re-wait.

Test Plan:
- Reset release, pll_lock high from cycle 100, SETTLE=64, STABLE=1024 → done pulses once, video_rst falls the following cycle; codes idsel=49, fbdsel=50, odsel=56 (mode0).
- In RUN, cfg_mode=2 with cfg_valid → cfg_ready drops next cycle, idsel=60, fbdsel=53, odsel=60, video_rst=1 until requalified.
- pll_lock held low, TIMEOUT=200, MAX_RETRIES=3 → four APPLY entries, then fault=1, done pulse, cfg_ready=1, video_rst=1.
- In RUN, pll_lock low 5 cycles → lock_lost=1 and video_rst=1 within 3 cycles; lock restored → RUN after 1024 stable cycles, lock_lost stays set.
- Lock glitching low every 500 cycles in WAIT_LOCK → no qualification. Glitch removed → done exactly 1024+2 cycles later.
- Reset asserted mid-WAIT_LOCK after mode3 request → immediate video_rst=1, cur_mode=0, fault=0. With the macro defined, pll_reset high for APPLY+16 cycles.
